// File: rtl/register_file_pkg.sv
// register_file_pkg
//   Shared constants for the MIPS general-purpose register file: default
//   geometry, the hardwired-zero index and a few named ABI registers.
package register_file_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int NUM_REGS       = 32;

    // $zero: reads as 0, writes discarded
    localparam logic [4:0] ZERO_REG = 5'd0;

    // Named MIPS indices used by the rest of the datapath
    localparam logic [4:0] REG_SP = 5'd29;
    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/register_file.sv
// register_file
//   Dual-read, single-write general-purpose register file for the MIPS
//   datapath. Writes commit on the falling edge of clk so that a value
//   written in the first half-cycle is readable in the second half.
//   Reads are purely combinational. Register 0 always reads as zero.
//
// Ports
//   clk              clock; writes commit on falling edge
//   rst              async active-high reset, clears every register
//   readRegister1/2  source operand indices
//   readData1/2      source operand data (combinational)
//   writeRegister    destination index
//   writeBack        data to write
//   RegisterWrite    write enable
//   MemoryToRegister, MemoryWrite, Branch, ALUSrc
//                    decoder controls routed here; reserved, no effect
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    input  logic [ADDR_WIDTH-1:0] writeRegister,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    input  logic [DATA_WIDTH-1:0] writeBack,
    input  logic                  RegisterWrite,
    input  logic                  MemoryToRegister,
    input  logic                  MemoryWrite,
    input  logic                  Branch,
    input  logic                  ALUSrc
);

    localparam int REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regFile [REGS];

    logic writeEn;
    assign writeEn = RegisterWrite && (writeRegister != ZERO_IDX);

    // Falling-edge commit: write in first half-cycle, read in the second.
    // Reset is asynchronous and beats any write on the same edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                regFile[i] <= '0;
            end
        end else if (writeEn) begin
            regFile[writeRegister] <= writeBack;
        end
    end

    // Index 0 is forced to zero at the read mux rather than relying on the
    // stored entry, so $zero holds regardless of what sits in regFile[0].
    always_comb begin
        readData1 = '0;
        readData2 = '0;
        if (readRegister1 != ZERO_IDX) readData1 = regFile[readRegister1];
        if (readRegister2 != ZERO_IDX) readData2 = regFile[readRegister2];
    end

    // Reserved decoder controls: intentionally sunk here
    logic unusedCtrl;
    assign unusedCtrl = &{1'b0, MemoryToRegister, MemoryWrite, Branch, ALUSrc};

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
    import register_file_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  readRegister1, readRegister2, writeRegister;
    logic [31:0] readData1, readData2, writeBack;
    logic        RegisterWrite, MemoryToRegister, MemoryWrite, Branch, ALUSrc;

    register_file dut (
        .clk(clk), .rst(rst),
        .readRegister1(readRegister1), .readRegister2(readRegister2),
        .writeRegister(writeRegister),
        .readData1(readData1), .readData2(readData2),
        .writeBack(writeBack), .RegisterWrite(RegisterWrite),
        .MemoryToRegister(MemoryToRegister), .MemoryWrite(MemoryWrite),
        .Branch(Branch), .ALUSrc(ALUSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] sbq [$];
    logic [31:0] model [32];
    logic [31:0] exp1, exp2;

    // Drive one write for a full cycle; inputs change just after rising edge
    // and stay stable across the falling edge. Model updates alongside.
    task automatic doWrite(input logic [4:0] a, input logic [31:0] d, input logic en);
        @(posedge clk); #1;
        writeRegister = a; writeBack = d; RegisterWrite = en;
        @(negedge clk); #1;
        RegisterWrite = 1'b0;
        if (en && a != 5'd0) model[a] = d;
    endtask

    // Set read addresses and queue the model's expectation for both ports
    task automatic setRead(input logic [4:0] a1, input logic [4:0] a2);
        readRegister1 = a1; readRegister2 = a2;
        sbq.push_back(a1 == 5'd0 ? 32'h0 : model[a1]);
        sbq.push_back(a2 == 5'd0 ? 32'h0 : model[a2]);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        foreach (model[i]) model[i] = 32'h0;
        for (int a = 0; a < 32; a += 9) begin
            setRead(5'(a), 5'(31 - a));
            exp1 = sbq.pop_front(); exp2 = sbq.pop_front(); vectors += 2;
            if (readData1 !== exp1) begin miscompares++; $display("FAIL reset_rd1 a=%0d got %h want %h", a, readData1, exp1); end
            if (readData2 !== exp2) begin miscompares++; $display("FAIL reset_rd2 a=%0d got %h want %h", 31 - a, readData2, exp2); end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic_write();
        doWrite(5'd1, 32'hFFFFFFFF, 1'b1);
        setRead(5'd1, 5'd0);
        exp1 = sbq.pop_front(); exp2 = sbq.pop_front(); vectors += 2;
        if (readData1 !== 32'hFFFFFFFF || exp1 !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL write_r1 got %h want %h", readData1, 32'hFFFFFFFF); end
        if (readData2 !== exp2) begin miscompares++; $display("FAIL read_r0 got %h want %h", readData2, exp2); end
    endtask

    task automatic test_zero_reg();
        doWrite(5'd0, 32'h0FFFFFFF, 1'b1);
        setRead(5'd0, 5'd31);
        exp1 = sbq.pop_front(); exp2 = sbq.pop_front(); vectors += 2;
        if (readData1 !== 32'h0) begin miscompares++; $display("FAIL zero_reg got %h want %h", readData1, exp1); end
        if (readData2 !== 32'h0) begin miscompares++; $display("FAIL unwritten_r31 got %h want %h", readData2, exp2); end
    endtask

    task automatic test_write_disable();
        doWrite(5'd1, 32'h12345678, 1'b0);
        setRead(5'd1, 5'd1);
        exp1 = sbq.pop_front(); exp2 = sbq.pop_front(); vectors += 2;
        if (readData1 !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL we_off_rd1 got %h want %h", readData1, exp1); end
        if (readData2 !== exp2) begin miscompares++; $display("FAIL we_off_rd2 got %h want %h", readData2, exp2); end
    endtask

    task automatic test_dual_read();
        doWrite(5'd5, 32'hA5A5A5A5, 1'b1);
        doWrite(REG_RA, 32'h5A5A5A5A, 1'b1);
        setRead(5'd5, REG_RA);
        exp1 = sbq.pop_front(); exp2 = sbq.pop_front(); vectors += 2;
        if (readData1 !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL dual_r5 got %h want %h", readData1, exp1); end
        if (readData2 !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL dual_r31 got %h want %h", readData2, exp2); end
    endtask

    task automatic test_same_cycle();
        doWrite(5'd7, 32'h1, 1'b1);
        @(posedge clk); #1;
        writeRegister = 5'd7; writeBack = 32'h2; RegisterWrite = 1'b1;
        setRead(5'd7, 5'd7);
        exp1 = sbq.pop_front(); exp2 = sbq.pop_front(); vectors++;
        if (readData1 !== 32'h1) begin miscompares++; $display("FAIL same_cycle_old got %h want %h", readData1, exp1); end
        @(negedge clk); #1;
        model[7] = 32'h2;
        setRead(5'd7, 5'd7);
        exp1 = sbq.pop_front(); exp2 = sbq.pop_front(); vectors += 2;
        if (readData1 !== 32'h2) begin miscompares++; $display("FAIL same_cycle_new1 got %h want %h", readData1, exp1); end
        if (readData2 !== exp2) begin miscompares++; $display("FAIL same_cycle_new2 got %h want %h", readData2, exp2); end
        // Armed right after the falling edge: the rising edge must not commit
        writeBack = 32'h3;
        @(posedge clk); #1;
        setRead(5'd7, 5'd0);
        exp1 = sbq.pop_front(); exp2 = sbq.pop_front(); vectors++;
        if (readData1 !== 32'h2) begin miscompares++; $display("FAIL rise_no_effect got %h want %h", readData1, exp1); end
        @(negedge clk); #1;
        RegisterWrite = 1'b0;
        model[7] = 32'h3;
        setRead(5'd7, 5'd0);
        exp1 = sbq.pop_front(); exp2 = sbq.pop_front(); vectors++;
        if (readData1 !== exp1) begin miscompares++; $display("FAIL fall_commit got %h want %h", readData1, exp1); end
    endtask

    task automatic test_async_reset();
        doWrite(5'd2, 32'hDEADBEEF, 1'b1);
        doWrite(REG_SP, 32'hCAFEF00D, 1'b1);
        // Assert reset mid-cycle with a write armed; reset must win at negedge
        @(posedge clk); #2;
        writeRegister = 5'd9; writeBack = 32'h99; RegisterWrite = 1'b1;
        rst = 1'b1;
        foreach (model[i]) model[i] = 32'h0;
        setRead(5'd2, REG_SP);
        exp1 = sbq.pop_front(); exp2 = sbq.pop_front(); vectors += 2;
        if (readData1 !== exp1) begin miscompares++; $display("FAIL async_rst_r2 got %h want %h", readData1, exp1); end
        if (readData2 !== exp2) begin miscompares++; $display("FAIL async_rst_r29 got %h want %h", readData2, exp2); end
        @(negedge clk); #1;
        setRead(5'd9, 5'd7);
        exp1 = sbq.pop_front(); exp2 = sbq.pop_front(); vectors += 2;
        if (readData1 !== exp1) begin miscompares++; $display("FAIL rst_beats_write got %h want %h", readData1, exp1); end
        if (readData2 !== exp2) begin miscompares++; $display("FAIL rst_r7 got %h want %h", readData2, exp2); end
        RegisterWrite = 1'b0;
        rst = 1'b0;
        doWrite(5'd3, 32'h3, 1'b1);
        setRead(5'd3, 5'd2);
        exp1 = sbq.pop_front(); exp2 = sbq.pop_front(); vectors += 2;
        if (readData1 !== 32'h3) begin miscompares++; $display("FAIL post_rst_r3 got %h want %h", readData1, exp1); end
        if (readData2 !== exp2) begin miscompares++; $display("FAIL post_rst_r2 got %h want %h", readData2, exp2); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            doWrite(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
            setRead(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            exp1 = sbq.pop_front(); exp2 = sbq.pop_front(); vectors += 2;
            if (readData1 !== exp1) begin miscompares++; $display("FAIL rand_rd1 a=%0d got %h want %h", readRegister1, readData1, exp1); end
            if (readData2 !== exp2) begin miscompares++; $display("FAIL rand_rd2 a=%0d got %h want %h", readRegister2, readData2, exp2); end
        end
    endtask

    initial begin
        rst = 1'b0;
        readRegister1 = '0; readRegister2 = '0; writeRegister = '0;
        writeBack = '0; RegisterWrite = 1'b0;
        MemoryToRegister = 1'b1; MemoryWrite = 1'b1; Branch = 1'b1; ALUSrc = 1'b1;
        test_reset();
        test_basic_write();
        test_zero_reg();
        test_write_disable();
        test_dual_read();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
